instr_encoder: RTL and testbench
================================

# instr_encoder

Packs move descriptors into the 32-bit TTA instruction stream. Each accepted move becomes one op word plus zero, one or two trailing operand words, emitted in order with a running word address. It sits between the program loader / test sequencer and instruction memory. It is the producer of the stream the instruction decoder consumes, so field layout and operand-word rules must match the decoder bit-for-bit.

## Interface
- ADDR_WIDTH, 12: width of the word address counter.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- move_valid_i  in  1  descriptor present.
- move_ready_o  out  1  descriptor accepted on the edge where valid and ready are both high.
- src_unit_i  in  Unit (4)  source unit.
- si_i  in  12  source index.
- src_operand_i  in  32  source operand; used only when the source unit is UNIT_MEMORY_OPERAND or UNIT_ABS_OPERAND.
- dst_unit_i  in  Unit (4)  destination unit.
- di_i  in  12  destination index.
- dst_operand_i  in  32  destination operand; same rule, applied to the destination unit.
- word_valid_o  out  1  output word present.
- word_ready_i  in  1  downstream accepts the word.
- word_o  out  32  instruction or operand word.
- word_last_o  out  1  word_o is the final word of the current move.
- addr_o  out  ADDR_WIDTH  address of word_o.
- load_i  in  1  load the address counter.
- load_addr_i  in  ADDR_WIDTH  value to load.

## Operation
- States: IDLE, OP, SRC_OPND, DST_OPND.
- Op word layout: word_o[3:0]=src_unit, [15:4]=si, [19:16]=dst_unit, [31:20]=di.
- A unit needs an operand exactly when it is UNIT_MEMORY_OPERAND or UNIT_ABS_OPERAND.
- On descriptor accept:
  - Latch all descriptor fields.
  - Compute need_src and need_dst.
  - Go to OP.
- Leaving OP on a word handshake:
  - Go to SRC_OPND if need_src.
  - Otherwise go to DST_OPND if need_dst.
  - Otherwise finish the move.
- Leaving SRC_OPND on handshake: go to DST_OPND if need_dst, else finish the move.
- DST_OPND on handshake: finish the move.
- Finishing a move: go to OP if a new descriptor is accepted on the same edge, else go to IDLE.
- Operand order is fixed: source operand word always precedes destination operand word.
- word_valid_o is high in OP, SRC_OPND and DST_OPND.
- word_last_o is high on the final word of the move.
- move_ready_o = enabled && (state==IDLE || (word_valid_o && word_ready_i && word_last_o)).
  - enabled is a flop cleared by reset and set on the first clock after reset release.
  - This allows back-to-back moves without a bubble.
- Address counter:
  - Increments modulo 2^ADDR_WIDTH on each word handshake.
  - addr_o always equals the address of the word currently presented.
  - load_i sets the counter to load_addr_i on the next edge, overriding a concurrent increment.
  - load_i during a move is legal and redirects the remaining words of that move.

## Timing
- Reset (asynchronous assert):
  - state IDLE, word_valid_o 0, word_last_o 0, word_o 0, addr_o 0, move_ready_o 0, latched fields 0.
  - An in-flight move is discarded with no partial completion.
  - Deassertion must be synchronous to clk_i.
- Latency: descriptor accepted at edge N → op word valid in cycle N+1.
- Throughput: one word per cycle while word_ready_i is high. A 1/2/3-word move occupies 1/2/3 cycles.
- Backpressure: while word_valid_o && !word_ready_i, word_o, word_last_o and addr_o hold stable, and state does not change.
- Descriptor inputs are sampled only at accept; later changes are ignored.
- Outputs are registered except move_ready_o, which depends combinationally on word_ready_i.

## Structure
- Unit enum and the UNIT_MEMORY_OPERAND / UNIT_ABS_OPERAND constants come from the shared package, the same one the decoder uses.
- Add a shared package function needs_operand(Unit) so encoder and decoder cannot diverge.
- Add package constants for the field bit positions.
- The encoder state enum is local to this module.
- Single module; no sub-module.

## Test plan
- Reset, no-operand move, back-to-back:
  - Hold rst_ni low, then release. Require move_ready_o 0 during reset and for the first cycle after release, then 1.
  - Then send a move with src unit 4'h1, si 12'h123, dst unit 4'h2, di 12'hABC, neither unit an operand unit, with word_ready_i high.
  - Require one word 32'hABC2_1231 with word_last_o=1 and addr_o=0, valid in the cycle after accept.
  - Back-to-back 1-word moves with word_ready_i tied high: move_ready_o stays high, one word per cycle, addr_o 0,1,2,…
- Both operands: src UNIT_ABS_OPERAND with operand 32'hDEADBEEF, dst UNIT_MEMORY_OPERAND with operand 32'h0000_1000.
  - Require the op word, then 32'hDEADBEEF, then 32'h0000_1000, at addr 0,1,2.
  - word_last_o high only on the third word.
- Destination-only operand: dst operand unit with operand 32'h5555_AAAA, src not an operand unit.
  - Require exactly two words: op word, then 32'h5555_AAAA with word_last_o=1.
- Backpressure: drop word_ready_i for 3 cycles on the second word of a 3-word move.
  - Require word_o and addr_o stable and move_ready_o 0.
  - No duplicated or skipped words after release.
- Address wrap and load: ADDR_WIDTH=4, pulse load_i with load_addr_i 4'hF, then send a 2-word move.
  - Require addr_o 4'hF, then 4'h0.
  - load_i asserted on the same edge as a handshake: the loaded value wins.
- Reset mid-move: assert rst_ni low on the second word of a 3-word move.
  - Require word_valid_o to fall immediately and addr_o to return to 0.
  - After release the next move starts fresh with its op word.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
//   Definitions shared by the TTA instruction encoder and decoder: the Unit
//   enumeration, op-word field positions and the operand-word rule. Keeping
//   them in one place means producer and consumer of the stream cannot
//   disagree on the layout.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package instr_encoder_pkg;

    localparam int WORD_WIDTH  = 32;
    localparam int UNIT_WIDTH  = 4;
    localparam int INDEX_WIDTH = 12;

    // Op word field positions (LSB of each field).
    localparam int OP_SRC_UNIT_LSB = 0;
    localparam int OP_SI_LSB       = 4;
    localparam int OP_DST_UNIT_LSB = 16;
    localparam int OP_DI_LSB       = 20;

    typedef enum logic [UNIT_WIDTH-1:0] {
        UNIT_NONE           = 4'h0,
        UNIT_ALU            = 4'h1,
        UNIT_RF             = 4'h2,
        UNIT_LSU            = 4'h3,
        UNIT_BRANCH         = 4'h4,
        UNIT_IMM            = 4'h5,
        UNIT_MEMORY_OPERAND = 4'hD,
        UNIT_ABS_OPERAND    = 4'hE
    } Unit;

    // A unit carries a trailing 32-bit operand word exactly when it addresses
    // memory or an absolute operand.
    function automatic logic needs_operand(input Unit u);
        return (u == UNIT_MEMORY_OPERAND) || (u == UNIT_ABS_OPERAND);
    endfunction

    function automatic logic [WORD_WIDTH-1:0] pack_op_word(
        input Unit                    src_unit,
        input logic [INDEX_WIDTH-1:0] si,
        input Unit                    dst_unit,
        input logic [INDEX_WIDTH-1:0] di
    );
        logic [WORD_WIDTH-1:0] w;
        w = '0;
        w[OP_SRC_UNIT_LSB +: UNIT_WIDTH]  = src_unit;
        w[OP_SI_LSB       +: INDEX_WIDTH] = si;
        w[OP_DST_UNIT_LSB +: UNIT_WIDTH]  = dst_unit;
        w[OP_DI_LSB       +: INDEX_WIDTH] = di;
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// -----------------------------------------------------------------------------
// instr_encoder_if
//   Bundles the encoder's descriptor input channel, word output channel and
//   address-load controls.
//   slave  : the encoder (consumes descriptors, produces words)
//   master : the sequencer / memory side (produces descriptors, accepts words)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface instr_encoder_if #(
    parameter int ADDR_WIDTH = 12
) ();
    import instr_encoder_pkg::*;

    // Descriptor channel
    logic                   move_valid_i;
    logic                   move_ready_o;
    Unit                    src_unit_i;
    logic [INDEX_WIDTH-1:0] si_i;
    logic [WORD_WIDTH-1:0]  src_operand_i;
    Unit                    dst_unit_i;
    logic [INDEX_WIDTH-1:0] di_i;
    logic [WORD_WIDTH-1:0]  dst_operand_i;

    // Word channel
    logic                   word_valid_o;
    logic                   word_ready_i;
    logic [WORD_WIDTH-1:0]  word_o;
    logic                   word_last_o;
    logic [ADDR_WIDTH-1:0]  addr_o;

    // Address counter load
    logic                   load_i;
    logic [ADDR_WIDTH-1:0]  load_addr_i;

    modport slave (
        input  move_valid_i, src_unit_i, si_i, src_operand_i,
               dst_unit_i, di_i, dst_operand_i,
               word_ready_i, load_i, load_addr_i,
        output move_ready_o, word_valid_o, word_o, word_last_o, addr_o
    );

    modport master (
        output move_valid_i, src_unit_i, si_i, src_operand_i,
               dst_unit_i, di_i, dst_operand_i,
               word_ready_i, load_i, load_addr_i,
        input  move_ready_o, word_valid_o, word_o, word_last_o, addr_o
    );

endinterface

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//   Turns each accepted move descriptor into one op word followed by an
//   optional source operand word and an optional destination operand word,
//   each tagged with a running word address.
//   Ports:
//     clk_i   clock
//     rst_ni  asynchronous active-low reset (release synchronously to clk_i)
//     bus     instr_encoder_if.slave: descriptor in, word out, address load
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        SRC_OPND,
        DST_OPND
    } state_e;

    state_e                r_state;
    logic                  r_enabled;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_need_src;
    logic                  r_need_dst;
    logic [WORD_WIDTH-1:0] r_word;
    logic [WORD_WIDTH-1:0] r_src_opnd;
    logic [WORD_WIDTH-1:0] r_dst_opnd;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_word_hs;
    logic                  w_move_ready;
    logic                  w_move_acc;
    logic                  w_new_need_src;
    logic                  w_new_need_dst;
    logic [WORD_WIDTH-1:0] w_op_word;

    assign w_word_hs      = r_valid && bus.word_ready_i;
    // Ready either when idle or on the edge the final word of the current
    // move leaves, so consecutive moves stream without a bubble.
    assign w_move_ready   = r_enabled && ((r_state == IDLE) || (w_word_hs && r_last));
    assign w_move_acc     = bus.move_valid_i && w_move_ready;
    assign w_new_need_src = needs_operand(bus.src_unit_i);
    assign w_new_need_dst = needs_operand(bus.dst_unit_i);
    assign w_op_word      = pack_op_word(bus.src_unit_i, bus.si_i, bus.dst_unit_i, bus.di_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_enabled  <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_need_src <= 1'b0;
            r_need_dst <= 1'b0;
            r_word     <= '0;
            r_src_opnd <= '0;
            r_dst_opnd <= '0;
            r_addr     <= '0;
        end else begin
            r_enabled <= 1'b1;

            // A load takes priority over the increment of a concurrent handshake.
            if (bus.load_i) begin
                r_addr <= bus.load_addr_i;
            end else if (w_word_hs) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_move_acc) begin
                // The op word register holds the latched unit/index fields.
                r_state    <= OP;
                r_valid    <= 1'b1;
                r_word     <= w_op_word;
                r_last     <= !w_new_need_src && !w_new_need_dst;
                r_need_src <= w_new_need_src;
                r_need_dst <= w_new_need_dst;
                r_src_opnd <= bus.src_operand_i;
                r_dst_opnd <= bus.dst_operand_i;
            end else if (w_word_hs && r_last) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_word_hs) begin
                // Not the last word, so at least one operand word follows;
                // the source operand always goes first.
                case (r_state)
                    OP: begin
                        if (r_need_src) begin
                            r_state <= SRC_OPND;
                            r_word  <= r_src_opnd;
                            r_last  <= !r_need_dst;
                        end else begin
                            r_state <= DST_OPND;
                            r_word  <= r_dst_opnd;
                            r_last  <= 1'b1;
                        end
                    end
                    SRC_OPND: begin
                        r_state <= DST_OPND;
                        r_word  <= r_dst_opnd;
                        r_last  <= 1'b1;
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign bus.move_ready_o = w_move_ready;
    assign bus.word_valid_o = r_valid;
    assign bus.word_o       = r_word;
    assign bus.word_last_o  = r_last;
    assign bus.addr_o       = r_addr;

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int AW = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    instr_encoder_if #(.ADDR_WIDTH(AW)) bus ();

    instr_encoder #(.ADDR_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct packed {
        Unit         su;
        logic [11:0] si;
        Unit         du;
        logic [11:0] di;
        logic [31:0] so;
        logic [31:0] dop;
    } desc_t;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] exp_addr;
    int            n_checks = 0;
    int            n_pass   = 0;

    function automatic desc_t mk(input Unit su, input logic [11:0] si, input Unit du,
                                 input logic [11:0] di, input logic [31:0] so, input logic [31:0] dop);
        desc_t d;
        d.su = su; d.si = si; d.du = du; d.di = di; d.so = so; d.dop = dop;
        return d;
    endfunction

    // Present a descriptor and push the words it must produce.
    task automatic drive_desc(input desc_t d);
        logic ns, nd;
        ns = (d.su == UNIT_MEMORY_OPERAND) || (d.su == UNIT_ABS_OPERAND);
        nd = (d.du == UNIT_MEMORY_OPERAND) || (d.du == UNIT_ABS_OPERAND);
        bus.src_unit_i    = d.su;
        bus.si_i          = d.si;
        bus.dst_unit_i    = d.du;
        bus.di_i          = d.di;
        bus.src_operand_i = d.so;
        bus.dst_operand_i = d.dop;
        bus.move_valid_i  = 1'b1;
        exp_q.push_back(exp_t'{word: {d.di, d.du, d.si, d.su}, last: !ns && !nd});
        if (ns) exp_q.push_back(exp_t'{word: d.so, last: !nd});
        if (nd) exp_q.push_back(exp_t'{word: d.dop, last: 1'b1});
    endtask

    task automatic test_reset();
        #1;
        bus.move_valid_i = 1'b0; bus.word_ready_i = 1'b1; bus.load_i = 1'b0; bus.load_addr_i = '0;
        bus.src_unit_i = UNIT_NONE; bus.dst_unit_i = UNIT_NONE; bus.si_i = '0; bus.di_i = '0;
        bus.src_operand_i = '0; bus.dst_operand_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (bus.move_ready_o !== 1'b0) $display("FAIL reset_ready: got %b expected 0", bus.move_ready_o);
        else n_pass++;
        n_checks++;
        if ({bus.word_valid_o, bus.word_last_o, bus.word_o, bus.addr_o} !== {2'b00, 32'h0, 4'h0})
            $display("FAIL reset_outputs: got v=%b l=%b w=%h a=%h expected all 0",
                     bus.word_valid_o, bus.word_last_o, bus.word_o, bus.addr_o);
        else n_pass++;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_checks++;
        if (bus.move_ready_o !== 1'b0) $display("FAIL ready_first_cycle: got %b expected 0", bus.move_ready_o);
        else n_pass++;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        n_checks++;
        if (bus.move_ready_o !== 1'b1) $display("FAIL ready_after_enable: got %b expected 1", bus.move_ready_o);
        else n_pass++;
        @(posedge clk_i); #1;
        exp_addr = '0;
        exp_q.delete();
        $display("reset: released, encoder enabled");
    endtask

    task automatic test_single_move();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0, acc_cyc = -1, word_cyc = -1;
        logic hs, acc;
        ds.push_back(mk(Unit'(4'h1), 12'h123, Unit'(4'h2), 12'hABC, 32'h0, 32'h0));
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (acc) acc_cyc = cyc;
            if (hs) begin
                if (got == 0) word_cyc = cyc;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL single_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL single_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("single: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (hs) exp_addr++;
            if (acc) begin
                idx++;
                if (idx < ds.size()) drive_desc(ds[idx]); else bus.move_valid_i = 1'b0;
            end
            cyc++;
        end
        n_checks++;
        if (bus.word_o !== 32'hABC2_1231 || word_cyc - acc_cyc != 1)
            $display("FAIL single_latency: got word %h after %0d cycles expected ABC21231 after 1",
                     bus.word_o, word_cyc - acc_cyc);
        else n_pass++;
        n_checks++;
        if (cyc >= 50 || got != 1) $display("FAIL single_count: got %0d words expected 1", got);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0;
        logic hs, acc;
        for (int i = 0; i < 5; i++)
            ds.push_back(mk(Unit'(4'h1 + i), 12'h100 + 12'(i), Unit'(4'h3), 12'h200 + 12'(i), 32'h0, 32'h0));
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (got > 0 && idx < ds.size()) begin
                n_checks++;
                if ({bus.word_valid_o, bus.move_ready_o} !== 2'b11)
                    $display("FAIL b2b_no_bubble: got valid=%b ready=%b expected 1 1",
                             bus.word_valid_o, bus.move_ready_o);
                else n_pass++;
            end
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL b2b_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL b2b_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("b2b: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (hs) exp_addr++;
            if (acc) begin
                idx++;
                if (idx < ds.size()) drive_desc(ds[idx]); else bus.move_valid_i = 1'b0;
            end
            cyc++;
        end
        n_checks++;
        if (cyc != 6 || got != 5) $display("FAIL b2b_throughput: got %0d words in %0d cycles expected 5 in 6", got, cyc);
        else n_pass++;
    endtask

    task automatic test_operands();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0;
        logic hs, acc;
        bus.load_i = 1'b1; bus.load_addr_i = 4'h0;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        exp_addr = 4'h0;
        ds.push_back(mk(UNIT_ABS_OPERAND, 12'h011, UNIT_MEMORY_OPERAND, 12'h022, 32'hDEAD_BEEF, 32'h0000_1000));
        ds.push_back(mk(Unit'(4'h3), 12'h033, UNIT_MEMORY_OPERAND, 12'h044, 32'h1111_1111, 32'h5555_AAAA));
        ds.push_back(mk(UNIT_ABS_OPERAND, 12'h055, Unit'(4'h1), 12'h066, 32'h1234_5678, 32'h2222_2222));
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 60) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL opnd_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL opnd_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("opnd: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (hs) exp_addr++;
            if (acc) begin
                idx++;
                if (idx < ds.size()) drive_desc(ds[idx]); else bus.move_valid_i = 1'b0;
            end
            cyc++;
        end
        n_checks++;
        if (cyc >= 60 || got != 7) $display("FAIL opnd_count: got %0d words expected 7", got);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0, stall = 0;
        logic hs, acc, stalled = 1'b0;
        ds.push_back(mk(UNIT_MEMORY_OPERAND, 12'h0A0, UNIT_ABS_OPERAND, 12'h0B0, 32'hA5A5_0001, 32'h5A5A_0002));
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (bus.word_valid_o && !bus.word_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0 || bus.word_o !== exp_q[0].word || bus.addr_o !== exp_addr
                    || bus.move_ready_o !== 1'b0)
                    $display("FAIL bp_hold: got %h addr=%h ready=%b expected held word at addr=%h ready=0",
                             bus.word_o, bus.addr_o, bus.move_ready_o, exp_addr);
                else n_pass++;
                $display("bp: stalled addr=%h word=%h", bus.addr_o, bus.word_o);
            end
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL bp_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("bp: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (hs) exp_addr++;
            if (stall > 0) begin
                stall--;
                if (stall == 0) bus.word_ready_i = 1'b1;
            end else if (hs && got == 1 && !stalled) begin
                bus.word_ready_i = 1'b0;
                stall = 3;
                stalled = 1'b1;
            end
            if (acc) begin
                idx++;
                if (idx < ds.size()) drive_desc(ds[idx]); else bus.move_valid_i = 1'b0;
            end
            cyc++;
        end
        bus.word_ready_i = 1'b1;
        n_checks++;
        if (cyc >= 50 || got != 3) $display("FAIL bp_count: got %0d words expected 3", got);
        else n_pass++;
    endtask

    task automatic test_wrap_load();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0;
        logic hs, acc;
        bus.load_i = 1'b1; bus.load_addr_i = 4'hF;
        @(posedge clk_i); #1;
        bus.load_i = 1'b0;
        exp_addr = 4'hF;
        // First move: plain wrap. Second move: load lands on the op word's handshake.
        ds.push_back(mk(Unit'(4'h1), 12'h010, UNIT_MEMORY_OPERAND, 12'h020, 32'h0, 32'hCAFE_0001));
        ds.push_back(mk(UNIT_ABS_OPERAND, 12'h030, UNIT_ABS_OPERAND, 12'h040, 32'hCAFE_0002, 32'hCAFE_0003));
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (hs) begin
                if (got <= 1 || got == 3) begin
                    n_checks++;
                    if (bus.addr_o !== ((got == 0) ? 4'hF : (got == 1) ? 4'h0 : 4'h7))
                        $display("FAIL wrap_addr: got %h on word %0d expected %h", bus.addr_o, got,
                                 (got == 0) ? 4'hF : (got == 1) ? 4'h0 : 4'h7);
                    else n_pass++;
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL wrap_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL wrap_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("wrap: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (bus.load_i) begin
                exp_addr = bus.load_addr_i;
                bus.load_i = 1'b0;
            end else if (hs) begin
                exp_addr++;
            end
            if (acc) begin
                idx++;
                if (idx < ds.size()) drive_desc(ds[idx]); else bus.move_valid_i = 1'b0;
                if (idx == ds.size()) begin
                    bus.load_i = 1'b1;
                    bus.load_addr_i = 4'h7;
                end
            end
            cyc++;
        end
        n_checks++;
        if (cyc >= 50 || got != 5) $display("FAIL wrap_count: got %0d words expected 5", got);
        else n_pass++;
    endtask

    task automatic test_reset_mid_move();
        desc_t ds[$];
        exp_t  e;
        int idx = 0, cyc = 0, got = 0;
        logic hs, acc, done = 1'b0;
        ds.push_back(mk(UNIT_ABS_OPERAND, 12'h777, UNIT_MEMORY_OPERAND, 12'h888, 32'hBAD0_0001, 32'hBAD0_0002));
        drive_desc(ds[0]);
        while (!done && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (hs) got++;
            @(posedge clk_i); #1;
            if (acc) begin idx++; bus.move_valid_i = 1'b0; end
            if (hs && got == 1) begin
                // Second word is being presented now.
                rst_ni = 1'b0;
                #1;
                n_checks++;
                if ({bus.word_valid_o, bus.addr_o, bus.move_ready_o} !== {1'b0, 4'h0, 1'b0})
                    $display("FAIL midreset_clear: got valid=%b addr=%h ready=%b expected 0 0 0",
                             bus.word_valid_o, bus.addr_o, bus.move_ready_o);
                else n_pass++;
                $display("midreset: reset asserted during second word");
                done = 1'b1;
            end
            cyc++;
        end
        n_checks++;
        if (!done) $display("FAIL midreset_reach: got %0d words expected reset at word 2", got);
        else n_pass++;
        exp_q.delete();
        exp_addr = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        ds.delete();
        ds.push_back(mk(Unit'(4'h4), 12'h0F0, Unit'(4'h5), 12'h00F, 32'h0, 32'h0));
        idx = 0; cyc = 0; got = 0;
        drive_desc(ds[0]);
        while ((idx < ds.size() || exp_q.size() != 0) && cyc < 50) begin
            @(negedge clk_i);
            hs  = bus.word_valid_o && bus.word_ready_i;
            acc = bus.move_valid_i && bus.move_ready_o;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL midreset_word: got unexpected word %h expected none", bus.word_o);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.word_o, bus.word_last_o, bus.addr_o} !== {e.word, e.last, exp_addr})
                        $display("FAIL midreset_word: got %h last=%b addr=%h expected %h last=%b addr=%h",
                                 bus.word_o, bus.word_last_o, bus.addr_o, e.word, e.last, exp_addr);
                    else n_pass++;
                end
                $display("midreset: addr=%h word=%h last=%b", bus.addr_o, bus.word_o, bus.word_last_o);
                got++;
            end
            @(posedge clk_i); #1;
            if (hs) exp_addr++;
            if (acc) begin idx++; bus.move_valid_i = 1'b0; end
            cyc++;
        end
        n_checks++;
        if (cyc >= 50 || got != 1) $display("FAIL midreset_count: got %0d words expected 1", got);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_back_to_back();
        test_operands();
        test_backpressure();
        test_wrap_load();
        test_reset_mid_move();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000ns");
        $fatal(1);
    end

endmodule
